// File: rtl/controle_vendas.sv
// controle_vendas: main vending state machine (MEF principal), feeding the display driver.
// Purpose : latches a product code, collects coins against the product price,
//           returns credit on cancel, timeout or rejected coin, and drives the
//           dispense command for the delivery mechanism.
// Optional: define TROCO_EN to add the troco output (change due on delivery).
// Ports   : clk, rst_n (async, active-low)
//           codigo[3:0]      product-code switches (level)
//           confirmar        confirm button (rising edge used)
//           cancelar         cancel button (rising edge used)
//           inserir          coin strobe (rising edge used)
//           moeda[1:0]       coin type: 00 none, 01 0,25, 10 0,50, 11 1,00
//           estado[1:0]      00 espera, 01 produto, 10 comparador, 11 entrega
//           produto[3:0]     latched code, 1111 = invalid
//           valorMoedas[3:0] credit in quarters, 0..8
//           devolver         one-cycle credit-return / coin-reject pulse
//           troco[3:0]       change due (TROCO_EN only)
//           liberar          dispense command, high throughout entrega
module controle_vendas #(
   parameter int unsigned TEMPO_ERRO    = 100000000,
   parameter int unsigned TIMEOUT       = 500000000,
   parameter int unsigned TEMPO_ENTREGA = 150000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] codigo,
   input  logic       confirmar,
   input  logic       cancelar,
   input  logic       inserir,
   input  logic [1:0] moeda,
   output logic [1:0] estado,
   output logic [3:0] produto,
   output logic [3:0] valorMoedas,
   output logic       devolver,
`ifdef TROCO_EN
   output logic [3:0] troco,
`endif
   output logic       liberar
);

   typedef enum logic [1:0] {
      ESPERA     = 2'b00,
      PRODUTO    = 2'b01,
      COMPARADOR = 2'b10,
      ENTREGA    = 2'b11
   } estado_t;

   localparam logic [31:0] ERRO_FIM  = 32'(TEMPO_ERRO - 1);
   localparam logic [31:0] TOUT_FIM  = 32'(TIMEOUT - 1);
   localparam logic [31:0] ENTR_FIM  = 32'(TEMPO_ENTREGA - 1);
   localparam logic [3:0]  COD_INVAL = 4'b1111;
   localparam logic [4:0]  CRED_MAX  = 5'd8;

   // Price in quarters; 0 marks a code that is not on sale.
   function automatic logic [3:0] preco_f(input logic [3:0] c);
      case (c)
         4'b0000: preco_f = 4'd4;
         4'b0100: preco_f = 4'd6;
         4'b0101: preco_f = 4'd3;
         4'b1000: preco_f = 4'd2;
         4'b1001: preco_f = 4'd5;
         4'b1010: preco_f = 4'd7;
         4'b1011: preco_f = 4'd2;
         4'b1100: preco_f = 4'd8;
         4'b1101: preco_f = 4'd8;
         default: preco_f = 4'd0;
      endcase
   endfunction

   function automatic logic valido_f(input logic [3:0] c);
      valido_f = (preco_f(c) != 4'd0);
   endfunction

   estado_t     estado_q, estado_d;
   logic [3:0]  produto_q, produto_d;
   logic [3:0]  valor_q, valor_d;
   logic [31:0] timer_q, timer_d;
   logic        erro_q, erro_d;
   logic        devolver_q, devolver_d;
   logic        conf_prev_q, canc_prev_q, ins_prev_q;
`ifdef TROCO_EN
   logic [3:0]  troco_q, troco_d;
   logic [3:0]  troco_w;
`endif

   logic       ev_conf, ev_canc, ev_ins;
   logic       coin_ev, cabe, pago, prod_ok, codigo_ok;
   logic       err_fim, tout, entr_fim;
   logic [3:0] preco;
   logic [4:0] add, soma;

   assign ev_conf = confirmar & ~conf_prev_q;
   assign ev_canc = cancelar  & ~canc_prev_q;
   assign ev_ins  = inserir   & ~ins_prev_q;

   always_comb begin
      add = 5'd0;
      case (moeda)
         2'b01:   add = 5'd1;
         2'b10:   add = 5'd2;
         2'b11:   add = 5'd4;
         default: add = 5'd0;
      endcase
   end

   // Five bits so a sum above 8 is visible before it is committed.
   assign soma      = {1'b0, valor_q} + add;
   assign cabe      = (soma <= CRED_MAX);
   assign coin_ev   = ev_ins & (moeda != 2'b00);
   assign preco     = preco_f(produto_q);
   assign prod_ok   = valido_f(produto_q);
   assign codigo_ok = valido_f(codigo);
   // Uses the registered credit, so payment is seen the cycle after a coin.
   assign pago      = (valor_q >= preco);
   assign err_fim   = (timer_q == ERRO_FIM);
   assign tout      = (timer_q == TOUT_FIM);
   assign entr_fim  = (timer_q == ENTR_FIM);
`ifdef TROCO_EN
   assign troco_w   = valor_q - preco;
`endif

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= ESPERA;
         produto_q   <= '0;
         valor_q     <= '0;
         timer_q     <= '0;
         erro_q      <= 1'b0;
         devolver_q  <= 1'b0;
         conf_prev_q <= 1'b0;
         canc_prev_q <= 1'b0;
         ins_prev_q  <= 1'b0;
`ifdef TROCO_EN
         troco_q     <= '0;
`endif
      end else begin
         estado_q    <= estado_d;
         produto_q   <= produto_d;
         valor_q     <= valor_d;
         timer_q     <= timer_d;
         erro_q      <= erro_d;
         devolver_q  <= devolver_d;
         conf_prev_q <= confirmar;
         canc_prev_q <= cancelar;
         ins_prev_q  <= inserir;
`ifdef TROCO_EN
         troco_q     <= troco_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
         ESPERA: begin
            if (ev_conf) estado_d = PRODUTO;
         end
         PRODUTO: begin
            if (!prod_ok) begin
               if (err_fim) estado_d = ESPERA;
            end else if (ev_canc) begin
               estado_d = ESPERA;
            end else if (ev_conf) begin
               estado_d = COMPARADOR;
            end
         end
         COMPARADOR: begin
            if (erro_q) begin
               if (err_fim) estado_d = ESPERA;
            end else if (pago) begin
               estado_d = ENTREGA;
            end else if (ev_canc) begin
               estado_d = ESPERA;
            end else if (!coin_ev && tout) begin
               estado_d = ESPERA;
            end
         end
         ENTREGA: begin
            if (entr_fim) estado_d = ESPERA;
         end
      endcase
   end

   // Datapath / output-register logic
   always_comb begin
      produto_d  = produto_q;
      valor_d    = valor_q;
      timer_d    = timer_q;
      erro_d     = erro_q;
      devolver_d = 1'b0;
`ifdef TROCO_EN
      troco_d    = troco_q;
`endif
      unique case (estado_q)
         ESPERA: begin
            timer_d = '0;
            if (ev_conf) produto_d = codigo_ok ? codigo : COD_INVAL;
         end
         PRODUTO: begin
            if (!prod_ok) timer_d = timer_q + 32'd1;
            if (estado_d == COMPARADOR) timer_d = '0;
         end
         COMPARADOR: begin
            if (erro_q) begin
               timer_d = timer_q + 32'd1;
            end else if (pago) begin
               timer_d = '0;
`ifdef TROCO_EN
               troco_d    = troco_w;
               devolver_d = (troco_w != 4'd0);
`endif
            end else if (ev_canc || (!coin_ev && tout)) begin
               devolver_d = (valor_q != 4'd0);
            end else if (coin_ev) begin
               timer_d = '0;
               if (cabe) begin
                  valor_d = soma[3:0];
               end else begin
                  devolver_d = 1'b1;
                  erro_d     = 1'b1;
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ENTREGA: begin
            timer_d = timer_q + 32'd1;
         end
      endcase
      // Every return to espera drops credit, code, timer and error hold.
      if (estado_d == ESPERA) begin
         produto_d = '0;
         valor_d   = '0;
         timer_d   = '0;
         erro_d    = 1'b0;
`ifdef TROCO_EN
         troco_d   = '0;
`endif
      end
   end

   assign estado      = estado_q;
   assign produto     = produto_q;
   assign valorMoedas = valor_q;
   assign devolver    = devolver_q;
   assign liberar     = (estado_q == ENTREGA);
`ifdef TROCO_EN
   assign troco       = troco_q;
`endif

endmodule
